// File: rtl/axi_arbiter_pkg.sv
// Shared widths, AXI request codes and arbiter enums for the icache/dcache to AXI bridge path.
`ifndef CACHE_SVH
`define CACHE_SVH
`define ADDRESS_WIDTH   32
`define DATA_WIDTH      32
`define BLOCK_WIDTH     256
`define AXI_STRB_WIDTH  4
`define AXI_REQ_WIDTH   3
`endif

package axi_arbiter_pkg;

    localparam int ADDR_W  = `ADDRESS_WIDTH;
    localparam int DATA_W  = `DATA_WIDTH;
    localparam int BLOCK_W = `BLOCK_WIDTH;
    localparam int STRB_W  = `AXI_STRB_WIDTH;
    localparam int REQ_W   = `AXI_REQ_WIDTH;

    typedef logic [REQ_W-1:0] axi_req_t;

    localparam axi_req_t REQ_TO_AXI_NONE        = 3'd0;
    localparam axi_req_t REQ_TO_AXI_LOAD_WORD   = 3'd1;
    localparam axi_req_t REQ_TO_AXI_WRITE_WORD  = 3'd2;
    localparam axi_req_t REQ_TO_AXI_LOAD_BLOCK  = 3'd3;
    localparam axi_req_t REQ_TO_AXI_WRITE_BLOCK = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/axi_arbiter.sv
// Two-client (icache/dcache) arbiter in front of the single AXI bridge: one grant per
// bridge transaction, alternating priority on conflict, finish routed back to the owner.
module axi_arbiter
    import axi_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [REQ_W-1:0]   icache_req,
    input  logic [ADDR_W-1:0]  icache_ad,
    input  logic [2:0]         icache_rword_en,
    output logic               icache_finish,
    input  logic [REQ_W-1:0]   dcache_req,
    input  logic [ADDR_W-1:0]  dcache_ad,
    input  logic [BLOCK_W-1:0] dcache_wblock,
    input  logic [DATA_W-1:0]  dcache_wword,
    input  logic [STRB_W-1:0]  dcache_wword_en,
    input  logic [2:0]         dcache_rword_en,
    output logic               dcache_finish,
    output logic [BLOCK_W-1:0] rblock,
    output logic [DATA_W-1:0]  rword,
    output logic [REQ_W-1:0]   bridge_req,
    output logic [ADDR_W-1:0]  bridge_ad,
    output logic [BLOCK_W-1:0] bridge_wblock,
    output logic [DATA_W-1:0]  bridge_wword,
    output logic [STRB_W-1:0]  bridge_wword_en,
    output logic [2:0]         bridge_rword_en,
    input  logic               bridge_ready,
    input  logic               bridge_task_finish,
    input  logic [BLOCK_W-1:0] bridge_rblock,
    input  logic [DATA_W-1:0]  bridge_rword
);

    arb_state_t state, state_next;
    arb_owner_t owner, last_grant, winner;
    axi_req_t   req_q;
    logic       icache_pending, dcache_pending, grant;

    // Icache write codes are illegal and simply never count as pending.
    assign icache_pending = (icache_req == REQ_TO_AXI_LOAD_WORD) ||
                            (icache_req == REQ_TO_AXI_LOAD_BLOCK);
    assign dcache_pending = (dcache_req != REQ_TO_AXI_NONE);
    assign grant  = (state == IDLE) && bridge_ready && (icache_pending || dcache_pending);
    assign winner = (dcache_pending && (!icache_pending || last_grant == ARB_ICACHE))
                  ? ARB_DCACHE : ARB_ICACHE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bridge_task_finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The bridge samples wword/wblock live after taking the request, so the payload
    // registers only change at a grant edge and stay frozen through WAIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner           <= ARB_ICACHE;
            last_grant      <= ARB_ICACHE;
            req_q           <= REQ_TO_AXI_NONE;
            bridge_ad       <= '0;
            bridge_rword_en <= '0;
            bridge_wblock   <= '0;
            bridge_wword    <= '0;
            bridge_wword_en <= '0;
        end else if (grant) begin
            owner      <= winner;
            last_grant <= winner;
            if (winner == ARB_DCACHE) begin
                req_q           <= dcache_req;
                bridge_ad       <= dcache_ad;
                bridge_rword_en <= dcache_rword_en;
                bridge_wblock   <= dcache_wblock;
                bridge_wword    <= dcache_wword;
                bridge_wword_en <= dcache_wword_en;
            end else begin
                req_q           <= icache_req;
                bridge_ad       <= icache_ad;
                bridge_rword_en <= icache_rword_en;
                bridge_wblock   <= '0;
                bridge_wword    <= '0;
                bridge_wword_en <= '0;
            end
        end
    end

    // NOTE: finish is decoded from state, not registered, so it lands in the same
    // cycle as bridge_task_finish and an async reset clears it without a clock edge.
    always_comb begin
        bridge_req    = REQ_TO_AXI_NONE;
        icache_finish = 1'b0;
        dcache_finish = 1'b0;
        if (state == ISSUE) bridge_req = req_q;
        if (state == WAIT && bridge_task_finish) begin
            icache_finish = (owner == ARB_ICACHE);
            dcache_finish = (owner == ARB_DCACHE);
        end
    end

    assign rblock = bridge_rblock;
    assign rword  = bridge_rword;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: stimulus pushes expected bridge requests and finish
// owners into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_arbiter;
    import axi_arbiter_pkg::*;

    typedef struct {
        axi_req_t             req;
        logic [ADDR_W-1:0]    ad;
        logic [2:0]           rword_en;
        logic [BLOCK_W-1:0]   wblock;
        logic [DATA_W-1:0]    wword;
        logic [STRB_W-1:0]    wword_en;
    } exp_req_t;

    logic clk = 1'b0;
    logic rstn;
    logic [REQ_W-1:0]   icache_req, dcache_req, bridge_req;
    logic [ADDR_W-1:0]  icache_ad, dcache_ad, bridge_ad;
    logic [2:0]         icache_rword_en, dcache_rword_en, bridge_rword_en;
    logic               icache_finish, dcache_finish;
    logic [BLOCK_W-1:0] dcache_wblock, bridge_wblock, rblock, bridge_rblock;
    logic [DATA_W-1:0]  dcache_wword, bridge_wword, rword, bridge_rword;
    logic [STRB_W-1:0]  dcache_wword_en, bridge_wword_en;
    logic               bridge_ready, bridge_task_finish;

    int total = 0;
    int bad   = 0;
    exp_req_t   exp_req_q[$];
    arb_owner_t exp_fin_q[$];

    always #5 clk = ~clk;

    axi_arbiter dut (
        .clk(clk), .rstn(rstn),
        .icache_req(icache_req), .icache_ad(icache_ad), .icache_rword_en(icache_rword_en),
        .icache_finish(icache_finish),
        .dcache_req(dcache_req), .dcache_ad(dcache_ad), .dcache_wblock(dcache_wblock),
        .dcache_wword(dcache_wword), .dcache_wword_en(dcache_wword_en),
        .dcache_rword_en(dcache_rword_en), .dcache_finish(dcache_finish),
        .rblock(rblock), .rword(rword),
        .bridge_req(bridge_req), .bridge_ad(bridge_ad), .bridge_wblock(bridge_wblock),
        .bridge_wword(bridge_wword), .bridge_wword_en(bridge_wword_en),
        .bridge_rword_en(bridge_rword_en), .bridge_ready(bridge_ready),
        .bridge_task_finish(bridge_task_finish), .bridge_rblock(bridge_rblock),
        .bridge_rword(bridge_rword)
    );

    task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                         input logic [BLOCK_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every bridge request and every finish pulse.
    always @(negedge clk) begin
        if (bridge_req != REQ_TO_AXI_NONE) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_bridge_req", BLOCK_W'(bridge_req), '0);
            end else begin
                exp_req_t e;
                e = exp_req_q.pop_front();
                check("bridge_req",      BLOCK_W'(bridge_req),      BLOCK_W'(e.req));
                check("bridge_ad",       BLOCK_W'(bridge_ad),       BLOCK_W'(e.ad));
                check("bridge_rword_en", BLOCK_W'(bridge_rword_en), BLOCK_W'(e.rword_en));
                check("bridge_wblock",   bridge_wblock,             e.wblock);
                check("bridge_wword",    BLOCK_W'(bridge_wword),    BLOCK_W'(e.wword));
                check("bridge_wword_en", BLOCK_W'(bridge_wword_en), BLOCK_W'(e.wword_en));
            end
        end
        if (icache_finish || dcache_finish) begin
            if (exp_fin_q.size() == 0) begin
                check("unexpected_finish", BLOCK_W'({icache_finish, dcache_finish}), '0);
            end else begin
                arb_owner_t o;
                o = exp_fin_q.pop_front();
                check("finish_owner", BLOCK_W'({icache_finish, dcache_finish}),
                      (o == ARB_ICACHE) ? BLOCK_W'(2'b10) : BLOCK_W'(2'b01));
                check("rblock_pass", rblock, bridge_rblock);
                check("rword_pass",  BLOCK_W'(rword), BLOCK_W'(bridge_rword));
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic push_req(input axi_req_t req, input logic [ADDR_W-1:0] ad,
                            input logic [2:0] ren, input logic [BLOCK_W-1:0] wb,
                            input logic [DATA_W-1:0] ww, input logic [STRB_W-1:0] we);
        exp_req_t e;
        e.req = req; e.ad = ad; e.rword_en = ren; e.wblock = wb; e.wword = ww; e.wword_en = we;
        exp_req_q.push_back(e);
    endtask

    // Bounded wait for the bridge request to appear (sampled at negedge).
    task automatic wait_bridge_req(input string name);
        int n = 0;
        while (bridge_req == REQ_TO_AXI_NONE && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bridge_req == REQ_TO_AXI_NONE) check({name, "_timeout"}, 1, 0);
    endtask

    // One-cycle bridge completion for the given owner, then that client drops its request.
    task automatic complete(input arb_owner_t o, input logic [DATA_W-1:0] rw);
        drive_edge();
        bridge_task_finish = 1'b1;
        bridge_rword  = rw;
        bridge_rblock = {8{rw}};
        exp_fin_q.push_back(o);
        drive_edge();
        bridge_task_finish = 1'b0;
        if (o == ARB_ICACHE) icache_req = REQ_TO_AXI_NONE;
        else                 dcache_req = REQ_TO_AXI_NONE;
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        icache_req = REQ_TO_AXI_NONE;
        dcache_req = REQ_TO_AXI_NONE;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    logic [BLOCK_W-1:0] wb_pat;

    initial begin
        rstn = 1'b0;
        icache_req = REQ_TO_AXI_NONE; icache_ad = '0; icache_rword_en = '0;
        dcache_req = REQ_TO_AXI_NONE; dcache_ad = '0; dcache_wblock = '0;
        dcache_wword = '0; dcache_wword_en = '0; dcache_rword_en = '0;
        bridge_ready = 1'b1; bridge_task_finish = 1'b0;
        bridge_rblock = '0; bridge_rword = '0;
        wb_pat = {8{32'hCAFE0000}} ^ {32{8'h5A}};

        #1;
        check("rst_bridge_req", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        check("rst_bridge_ad",  BLOCK_W'(bridge_ad), '0);
        check("rst_wblock",     bridge_wblock, '0);
        check("rst_finish",     BLOCK_W'({icache_finish, dcache_finish}), '0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Icache LOAD_BLOCK alone: one-cycle request, icache gets the finish.
        drive_edge();
        icache_req = REQ_TO_AXI_LOAD_BLOCK; icache_ad = 32'h1C000020; icache_rword_en = 3'd2;
        push_req(REQ_TO_AXI_LOAD_BLOCK, 32'h1C000020, 3'd2, '0, '0, '0);
        @(negedge clk);
        check("lat_before_grant", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        @(negedge clk);
        check("lat_grant", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_LOAD_BLOCK));
        @(negedge clk);
        check("req_one_cycle", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        check("wait_no_finish", BLOCK_W'({icache_finish, dcache_finish}), '0);
        complete(ARB_ICACHE, 32'h11112222);

        // Dcache WRITE_WORD: payload must stay frozen while the client inputs change.
        drive_edge();
        dcache_req = REQ_TO_AXI_WRITE_WORD; dcache_ad = 32'hA0000010;
        dcache_wword = 32'hDEADBEEF; dcache_wword_en = 4'b0011; dcache_rword_en = 3'd2;
        dcache_wblock = wb_pat;
        push_req(REQ_TO_AXI_WRITE_WORD, 32'hA0000010, 3'd2, wb_pat, 32'hDEADBEEF, 4'b0011);
        @(negedge clk);
        wait_bridge_req("store");
        drive_edge();
        dcache_wword = 32'h0; dcache_wword_en = 4'hF; dcache_wblock = '0;
        repeat (2) begin
            @(negedge clk);
            check("hold_wword",    BLOCK_W'(bridge_wword), BLOCK_W'(32'hDEADBEEF));
            check("hold_wword_en", BLOCK_W'(bridge_wword_en), BLOCK_W'(4'b0011));
            check("hold_wblock",   bridge_wblock, wb_pat);
        end
        complete(ARB_DCACHE, 32'h33334444);

        // Tie from reset: dcache first, then icache, then dcache wins the next tie.
        do_reset();
        drive_edge();
        dcache_wblock = wb_pat; dcache_wword = 32'h01020304; dcache_wword_en = 4'hF;
        dcache_req = REQ_TO_AXI_WRITE_BLOCK; dcache_ad = 32'h00001000; dcache_rword_en = 3'd0;
        icache_req = REQ_TO_AXI_LOAD_BLOCK;  icache_ad = 32'h1C000040; icache_rword_en = 3'd1;
        push_req(REQ_TO_AXI_WRITE_BLOCK, 32'h00001000, 3'd0, wb_pat, 32'h01020304, 4'hF);
        push_req(REQ_TO_AXI_LOAD_BLOCK,  32'h1C000040, 3'd1, '0, '0, '0);
        @(negedge clk);
        wait_bridge_req("tie1_d");
        complete(ARB_DCACHE, 32'h55556666);
        @(negedge clk);
        wait_bridge_req("tie1_i");
        complete(ARB_ICACHE, 32'h77778888);
        dcache_req = REQ_TO_AXI_LOAD_WORD; dcache_ad = 32'h00002004; dcache_rword_en = 3'd2;
        icache_req = REQ_TO_AXI_LOAD_WORD; icache_ad = 32'h1C000080; icache_rword_en = 3'd2;
        push_req(REQ_TO_AXI_LOAD_WORD, 32'h00002004, 3'd2, wb_pat, 32'h01020304, 4'hF);
        push_req(REQ_TO_AXI_LOAD_WORD, 32'h1C000080, 3'd2, '0, '0, '0);
        @(negedge clk);
        wait_bridge_req("tie2_d");
        complete(ARB_DCACHE, 32'h9999AAAA);
        @(negedge clk);
        wait_bridge_req("tie2_i");
        complete(ARB_ICACHE, 32'hBBBBCCCC);

        // Bridge busy: no grant until bridge_ready, then one-cycle latency.
        bridge_ready = 1'b0;
        dcache_req = REQ_TO_AXI_LOAD_WORD; dcache_ad = 32'h00003000; dcache_rword_en = 3'd1;
        push_req(REQ_TO_AXI_LOAD_WORD, 32'h00003000, 3'd1, wb_pat, 32'h01020304, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("busy_no_grant", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        end
        drive_edge();
        bridge_ready = 1'b1;
        @(negedge clk);
        check("ready_before_edge", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        @(negedge clk);
        check("ready_grant", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_LOAD_WORD));
        complete(ARB_DCACHE, 32'hDDDDEEEE);

        // Illegal icache write code: never granted and never wins a tie.
        icache_req = REQ_TO_AXI_WRITE_WORD; icache_ad = 32'h1C0000C0;
        repeat (4) begin
            @(negedge clk);
            check("illegal_no_grant", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_NONE));
        end
        drive_edge();
        dcache_req = REQ_TO_AXI_LOAD_WORD; dcache_ad = 32'h00004000; dcache_rword_en = 3'd2;
        push_req(REQ_TO_AXI_LOAD_WORD, 32'h00004000, 3'd2, wb_pat, 32'h01020304, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("illegal_still_idle", BLOCK_W'(bridge_req), BLOCK_W'(REQ_TO_AXI_LOAD_WORD));
        complete(ARB_DCACHE, 32'h12345678);
        icache_req = REQ_TO_AXI_NONE;

        // Async reset while in WAIT, then a late bridge finish.
        drive_edge();
        dcache_req = REQ_TO_AXI_WRITE_BLOCK; dcache_ad = 32'h00005000; dcache_rword_en = 3'd0;
        push_req(REQ_TO_AXI_WRITE_BLOCK, 32'h00005000, 3'd0, wb_pat, 32'h01020304, 4'hF);
        @(negedge clk);
        wait_bridge_req("rst_txn");
        drive_edge();
        #2 rstn = 1'b0;
        dcache_req = REQ_TO_AXI_NONE;
        bridge_task_finish = 1'b1;
        #1;
        check("async_rst_ad",     BLOCK_W'(bridge_ad), '0);
        check("async_rst_wblock", bridge_wblock, '0);
        check("async_rst_wword",  BLOCK_W'(bridge_wword), '0);
        check("async_rst_finish", BLOCK_W'({icache_finish, dcache_finish}), '0);
        drive_edge();
        rstn = 1'b1;
        bridge_task_finish = 1'b0;
        drive_edge();
        bridge_task_finish = 1'b1;
        @(negedge clk);
        check("late_finish", BLOCK_W'({icache_finish, dcache_finish}), '0);
        drive_edge();
        bridge_task_finish = 1'b0;
        repeat (3) @(negedge clk);

        check("req_queue_empty", BLOCK_W'(exp_req_q.size()), '0);
        check("fin_queue_empty", BLOCK_W'(exp_fin_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
